// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction loader. Parses a framed byte stream
// (sync, 16-bit word count, big-endian data words, XOR checksum), writes
// each word to the core's instruction-fill port and keeps the core in reset
// until a complete image with a matching checksum has been written.
module imem_loader #(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter int          MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  ByteIn,
   input  logic        ByteVal,
   output logic        ByteRdy,
   input  logic        Restart,
   output logic [31:0] IntrAddr_FL0,
   output logic [31:0] IntrFill_FL0,
   output logic        FillVal_FL0,
   output logic        CoreReset,
   output logic        LoadDone,
   output logic        LoadErr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_HI,
      S_CNT_LO,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [7:0]  SYNC_BYTE = 8'hA5;
   localparam logic [16:0] MAX_W     = 17'(MAX_WORDS);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] idx_q, idx_d;
   logic [1:0]  lane_q, lane_d;
   logic [23:0] word_q, word_d;
   logic [7:0]  csum_q, csum_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] fill_q, fill_d;
   logic        fval_q, fval_d;
   logic        core_rst_q, core_rst_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic        loading;
   logic        xfer;
   logic [15:0] count_full;

   // Ready only while the frame is still being parsed and no restart or reset is pending.
   always_comb begin
      loading = (state_q == S_IDLE) || (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                (state_q == S_DATA) || (state_q == S_CSUM);
      ByteRdy = loading & ~Restart & reset;
      xfer    = ByteVal & ByteRdy;
   end

   // Frame parser: next state, word assembly, checksum and fill generation.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      lane_d     = lane_q;
      word_d     = word_q;
      csum_d     = csum_q;
      addr_d     = addr_q;
      fill_d     = fill_q;
      fval_d     = 1'b0;
      core_rst_d = core_rst_q;
      done_d     = done_q;
      err_d      = err_q;
      count_full = {cnt_q[15:8], ByteIn};

      if (Restart) begin
         state_d    = S_IDLE;
         core_rst_d = 1'b1;
         done_d     = 1'b0;
         err_d      = 1'b0;
         idx_d      = 16'd0;
         lane_d     = 2'd0;
         csum_d     = 8'd0;
      end else if (xfer) begin
         case (state_q)
            S_IDLE: begin
               if (ByteIn == SYNC_BYTE) begin
                  state_d = S_CNT_HI;
                  csum_d  = 8'd0;
                  idx_d   = 16'd0;
                  lane_d  = 2'd0;
               end
            end
            S_CNT_HI: begin
               cnt_d   = {ByteIn, 8'd0};
               state_d = S_CNT_LO;
            end
            S_CNT_LO: begin
               cnt_d = count_full;
               if ({1'b0, count_full} > MAX_W) begin
                  state_d    = S_ERR;
                  err_d      = 1'b1;
                  core_rst_d = 1'b1;
               end else if (count_full == 16'd0) begin
                  state_d = S_CSUM;
               end else begin
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
               csum_d = csum_q ^ ByteIn;
               lane_d = lane_q + 2'd1;
               if (lane_q == 2'd3) begin
                  fill_d = {word_q, ByteIn};
                  addr_d = ADDR_BASE + {14'd0, idx_q, 2'b00};
                  fval_d = 1'b1;
                  idx_d  = idx_q + 16'd1;
                  if ((idx_q + 16'd1) == cnt_q) begin
                     state_d = S_CSUM;
                  end
               end else begin
                  word_d = {word_q[15:0], ByteIn};
               end
            end
            S_CSUM: begin
               if (ByteIn == csum_q) begin
                  state_d    = S_DONE;
                  done_d     = 1'b1;
                  core_rst_d = 1'b0;
               end else begin
                  state_d    = S_ERR;
                  err_d      = 1'b1;
                  core_rst_d = 1'b1;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   // State and output registers; reset discards any partially assembled word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 16'd0;
         idx_q      <= 16'd0;
         lane_q     <= 2'd0;
         word_q     <= 24'd0;
         csum_q     <= 8'd0;
         addr_q     <= ADDR_BASE;
         fill_q     <= 32'd0;
         fval_q     <= 1'b0;
         core_rst_q <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         lane_q     <= lane_d;
         word_q     <= word_d;
         csum_q     <= csum_d;
         addr_q     <= addr_d;
         fill_q     <= fill_d;
         fval_q     <= fval_d;
         core_rst_q <= core_rst_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign IntrAddr_FL0 = addr_q;
   assign IntrFill_FL0 = fill_q;
   assign FillVal_FL0  = fval_q;
   assign CoreReset    = core_rst_q;
   assign LoadDone     = done_q;
   assign LoadErr      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives framed byte streams into two loader instances
// (default parameters, and ADDR_BASE=0x400 / MAX_WORDS=4) and compares the
// observed fills and status flags against a frame-level reference model.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rstN;
   logic [7:0]  byteIn;
   logic        byteVal;
   logic        restart;
   logic        byteRdy0, byteRdy1;
   logic [31:0] addr0, addr1, fill0, fill1;
   logic        fillVal0, fillVal1, coreRst0, coreRst1, done0, done1, err0, err1;

   imem_loader dut0 (
      .clk(clk), .reset(rstN), .ByteIn(byteIn), .ByteVal(byteVal), .ByteRdy(byteRdy0),
      .Restart(restart), .IntrAddr_FL0(addr0), .IntrFill_FL0(fill0), .FillVal_FL0(fillVal0),
      .CoreReset(coreRst0), .LoadDone(done0), .LoadErr(err0)
   );

   imem_loader #(.ADDR_BASE(32'h0000_0400), .MAX_WORDS(4)) dut1 (
      .clk(clk), .reset(rstN), .ByteIn(byteIn), .ByteVal(byteVal), .ByteRdy(byteRdy1),
      .Restart(restart), .IntrAddr_FL0(addr1), .IntrFill_FL0(fill1), .FillVal_FL0(fillVal1),
      .CoreReset(coreRst1), .LoadDone(done1), .LoadErr(err1)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } fill_t;

   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   fill_t      got0[$];
   fill_t      got1[$];
   fill_t      mdl[$];
   logic [7:0] sentB[$];
   int         sentCyc[$];
   logic [7:0] frame[$];

   // Free-running clock and edge counter used to time-stamp accepted bytes and fills.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Record every fill strobe of both instances away from the active edge.
   always @(negedge clk) begin
      if (fillVal0 === 1'b1) got0.push_back('{addr0, fill0, cyc});
      if (fillVal1 === 1'b1) got1.push_back('{addr1, fill1, cyc});
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one byte after an optional idle gap; returns on the falling edge after acceptance.
   task automatic applyStimulus(input logic [7:0] b, input int gap);
      for (int i = 0; i < gap; i++) begin
         byteVal = 1'b0;
         @(negedge clk);
      end
      byteVal = 1'b1;
      byteIn  = b;
      @(posedge clk);
      @(negedge clk);
      sentB.push_back(b);
      sentCyc.push_back(cyc);
   endtask

   task automatic sendFrame(input int maxGap, input int nBytes);
      for (int i = 0; i < nBytes && i < frame.size(); i++)
         applyStimulus(frame[i], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
      byteVal = 1'b0;
   endtask

   task automatic clearAll();
      sentB.delete();
      sentCyc.delete();
      got0.delete();
      got1.delete();
   endtask

   task automatic pulseRestart(input string tag);
      byteVal = 1'b0;
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      #1;
      checkOutput({tag, ".rst.done0"}, done0, 1'b0);
      checkOutput({tag, ".rst.err0"}, err0, 1'b0);
      checkOutput({tag, ".rst.core0"}, coreRst0, 1'b1);
      checkOutput({tag, ".rst.core1"}, coreRst1, 1'b1);
      checkOutput({tag, ".rst.rdy1"}, byteRdy1, 1'b1);
      clearAll();
   endtask

   // Frame-level reference: find the sync, read the count, slice the data into
   // big-endian words at base+4*i, fold the XOR and compare the trailing byte.
   task automatic runModel(input logic [31:0] base, input int maxW, output bit expDone, output bit expErr);
      int         p, n, count, q;
      logic [7:0] x;
      logic [31:0] w;
      mdl.delete();
      expDone = 1'b0;
      expErr  = 1'b0;
      n = sentB.size();
      p = 0;
      while (p < n && sentB[p] !== 8'hA5) p++;
      if (p + 2 >= n) return;
      count = int'({sentB[p+1], sentB[p+2]});
      if (count > maxW) begin
         expErr = 1'b1;
         return;
      end
      x = 8'h00;
      for (int i = 0; i < count; i++) begin
         q = p + 3 + 4 * i;
         if (q + 3 >= n) return;
         w = {sentB[q], sentB[q+1], sentB[q+2], sentB[q+3]};
         x = x ^ sentB[q] ^ sentB[q+1] ^ sentB[q+2] ^ sentB[q+3];
         mdl.push_back('{base + 32'(4 * i), w, sentCyc[q+3]});
      end
      q = p + 3 + 4 * count;
      if (q < n) begin
         expDone = (sentB[q] == x);
         expErr  = !expDone;
      end
   endtask

   task automatic checkDut(input int k, input string tag);
      bit    d, e;
      fill_t g;
      int    nGot;
      if (k == 0) runModel(32'h0, 1024, d, e);
      else        runModel(32'h400, 4, d, e);
      nGot = (k == 0) ? got0.size() : got1.size();
      checkOutput($sformatf("%s.d%0d.nfill", tag, k), nGot, mdl.size());
      for (int i = 0; i < mdl.size() && i < nGot; i++) begin
         g = (k == 0) ? got0[i] : got1[i];
         checkOutput($sformatf("%s.d%0d.addr%0d", tag, k, i), g.addr, mdl[i].addr);
         checkOutput($sformatf("%s.d%0d.data%0d", tag, k, i), g.data, mdl[i].data);
         checkOutput($sformatf("%s.d%0d.cyc%0d", tag, k, i), g.cyc, mdl[i].cyc);
      end
      checkOutput($sformatf("%s.d%0d.done", tag, k), (k == 0) ? done0 : done1, d);
      checkOutput($sformatf("%s.d%0d.err", tag, k), (k == 0) ? err0 : err1, e);
      checkOutput($sformatf("%s.d%0d.core", tag, k), (k == 0) ? coreRst0 : coreRst1, !d);
      checkOutput($sformatf("%s.d%0d.rdy", tag, k), (k == 0) ? byteRdy0 : byteRdy1, !(d || e));
   endtask

   task automatic checkScenario(input string tag);
      #1;
      checkDut(0, tag);
      checkDut(1, tag);
   endtask

   task automatic loadFixed(input logic [7:0] csum);
      logic [7:0] fixedBytes [12];
      fixedBytes = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                     8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
      frame.delete();
      for (int i = 0; i < 11; i++) frame.push_back(fixedBytes[i]);
      frame.push_back(csum);
   endtask

   task automatic loadRandom(input int count, input bit goodCsum);
      logic [7:0] b, x;
      frame.delete();
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'hA5) b = 8'h5A;
         frame.push_back(b);
      end
      frame.push_back(8'hA5);
      frame.push_back(8'(count >> 8));
      frame.push_back(8'(count));
      x = 8'h00;
      for (int i = 0; i < 4 * count; i++) begin
         b = 8'($urandom_range(0, 255));
         x ^= b;
         frame.push_back(b);
      end
      frame.push_back(goodCsum ? x : ~x);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, ".addr0"}, addr0, 32'h0);
      checkOutput({tag, ".addr1"}, addr1, 32'h400);
      checkOutput({tag, ".fill0"}, fill0, 32'h0);
      checkOutput({tag, ".fill1"}, fill1, 32'h0);
      checkOutput({tag, ".fval0"}, fillVal0, 1'b0);
      checkOutput({tag, ".core0"}, coreRst0, 1'b1);
      checkOutput({tag, ".done0"}, done0, 1'b0);
      checkOutput({tag, ".err0"}, err0, 1'b0);
      checkOutput({tag, ".rdy0"}, byteRdy0, 1'b0);
   endtask

   initial begin
      rstN    = 1'b0;
      byteVal = 1'b0;
      byteIn  = 8'h00;
      restart = 1'b0;
      #12;
      checkResetOutputs("reset");
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);

      $display("[TB] scenario 1: good two-word frame");
      clearAll();
      loadFixed(8'h00);
      sendFrame(0, 12);
      checkScenario("s1");
      checkOutput("s1.data0", (got0.size() > 0) ? got0[0].data : 32'hx, 32'h1234_5678);
      checkOutput("s1.data1", (got0.size() > 1) ? got0[1].data : 32'hx, 32'h9ABC_DEF0);
      checkOutput("s1.spacing", (got0.size() > 1) ? got0[1].cyc - got0[0].cyc : -1, 4);

      $display("[TB] scenario 2: bad checksum");
      pulseRestart("s2");
      loadFixed(8'h01);
      sendFrame(0, 12);
      checkScenario("s2");

      $display("[TB] scenario 3: leading junk and empty frame");
      pulseRestart("s3");
      loadFixed(8'h00);
      frame.push_front(8'h5A);
      frame.push_front(8'hFF);
      frame.push_front(8'h00);
      sendFrame(0, 15);
      checkScenario("s3");
      pulseRestart("s3b");
      frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
      sendFrame(0, 4);
      checkScenario("s3b");

      $display("[TB] scenario 4: count above MAX_WORDS");
      pulseRestart("s4");
      frame = '{8'hA5, 8'h00, 8'h05};
      sendFrame(0, 3);
      checkScenario("s4");

      $display("[TB] scenario 5: valid gaps");
      pulseRestart("s5");
      loadFixed(8'h00);
      sendFrame(3, 12);
      checkScenario("s5");

      $display("[TB] scenario 6: restart mid-frame");
      pulseRestart("s6");
      loadFixed(8'h00);
      sendFrame(0, 7);
      checkScenario("s6a");
      pulseRestart("s6b");
      sendFrame(0, 12);
      checkScenario("s6c");

      $display("[TB] scenario 7: random frames");
      for (int r = 0; r < 6; r++) begin
         pulseRestart($sformatf("r%0d", r));
         loadRandom(int'($urandom_range(1, 5)), ($urandom_range(0, 3) != 0));
         sendFrame(2, frame.size());
         checkScenario($sformatf("r%0d", r));
      end

      $display("[TB] scenario 8: asynchronous reset mid-word");
      pulseRestart("s8");
      loadRandom(3, 1'b1);
      sendFrame(0, frame.size() - 7);
      checkScenario("s8a");
      #2;
      rstN = 1'b0;
      #1;
      checkResetOutputs("s8rst");
      @(negedge clk);
      rstN = 1'b1;
      clearAll();
      loadRandom(3, 1'b1);
      sendFrame(1, frame.size());
      checkScenario("s8b");

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction loader that drives the core's instruction-fill port (`IntrAddr_FL0` / `IntrFill_FL0`), the writer side of that port. It receives a framed byte stream over a valid/ready interface from a host link and assembles big-endian 32-bit words. It writes the words to consecutive word addresses from `ADDR_BASE` and holds the core in reset until a complete, checksum-verified image has been written.

## Interface
- `ADDR_BASE`, default 32'h0000_0000: byte address of the first filled word; must be 4-byte aligned.
- `MAX_WORDS`, default 1024: largest accepted word count; range 1..65535.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ByteIn`  in  8  stream byte.
- `ByteVal`  in  1  `ByteIn` valid.
- `ByteRdy`  out  1  loader accepts a byte; a transfer occurs when `ByteVal & ByteRdy`.
- `Restart`  in  1  one-cycle request to abort or redo a load.
- `IntrAddr_FL0`  out  32  fill byte address.
- `IntrFill_FL0`  out  32  fill word.
- `FillVal_FL0`  out  1  one-cycle write strobe qualifying addr/data.
- `CoreReset`  out  1  active-high hold for the core's `reset` input.
- `LoadDone`  out  1  sticky: image loaded and verified.
- `LoadErr`  out  1  sticky: bad count or checksum.

## Operation
- Frame format: sync 0xA5, count high byte, count low byte, then 4·count data bytes (MSB first per word), then a checksum byte.
- The checksum is the XOR of all data bytes only.
- States and transitions:
  - IDLE: a byte equal to 0xA5 → CNT_HI. Any other byte is consumed and dropped.
  - CNT_HI: byte → CNT_LO.
  - CNT_LO: byte completes the 16-bit count.
    - count > `MAX_WORDS` → ERR.
    - count = 0 → CSUM.
    - otherwise → DATA.
  - DATA: a 2-bit byte lane counter shifts bytes into the word register. On lane 3:
    - pulse the fill; the word index increments.
    - after the last word → CSUM.
  - CSUM: byte equal to the running XOR → DONE; otherwise → ERR.
  - DONE: `LoadDone`=1, `CoreReset`=0.
  - ERR: `LoadErr`=1, `CoreReset`=1.
- `ByteRdy` = state ∈ {IDLE, CNT_HI, CNT_LO, DATA, CSUM} & ~`Restart` & `reset`. It is 0 in DONE and ERR.
- Fill address = `ADDR_BASE` + 4·index, using a 16-bit index and 32-bit addition with wrap modulo 2^32.
- The checksum accumulator and word index clear on entry to CNT_HI.
- Words already written stay written after an ERR; there is no rollback.
- `Restart` (any state): on the next edge go to IDLE and set `CoreReset`=1.
  - Clears `LoadDone`, `LoadErr`, index, lane and checksum.
  - Takes priority over a byte transfer in the same cycle; the byte is not accepted because `ByteRdy`=0.
- Reset (asynchronous, any time including mid-word):
  - state IDLE, `FillVal_FL0`=0, `IntrAddr_FL0`=`ADDR_BASE`, `IntrFill_FL0`=0.
  - `CoreReset`=1, `LoadDone`=0, `LoadErr`=0.
  - Lane, index and checksum are 0.
  - The partial word is discarded.

## Timing
- `IntrAddr_FL0`, `IntrFill_FL0`, `FillVal_FL0`, `CoreReset`, `LoadDone` and `LoadErr` are registered outputs. `ByteRdy` is combinational from state.
- Fill latency: the 4th byte of a word accepted at edge k gives `FillVal_FL0`=1 for exactly the cycle after edge k, with that word's address and data stable. Otherwise `FillVal_FL0`=0.
- Addr/data hold their last values between strobes.
- Back-to-back: with `ByteVal` held high, one byte per cycle and one fill every 4 cycles. No backpressure.
- Checksum byte accepted at edge k (match): `LoadDone`=1 and `CoreReset`=0 after edge k.
- Count error: after the CNT_LO edge, `LoadErr`=1.
- Gaps in `ByteVal` only stretch the timing; results are unchanged.

## Test plan
- Stream A5 00 02 12 34 56 78 9A BC DE F0 00 at 1 byte/cycle. Required response:
  - a fill strobe with addr 0x0, data 0x12345678;
  - 4 cycles later a fill strobe with addr 0x4, data 0x9ABCDEF0;
  - after the checksum byte, `LoadDone`=1, `CoreReset`=0, `LoadErr`=0, `ByteRdy`=0.
- Same frame with checksum 0x01. Required response: both fills occur, then `LoadErr`=1, `CoreReset` stays 1, `LoadDone`=0.
- Frame preceded by 00 FF 5A. Required response: leading bytes dropped, no fills before the sync, result identical to scenario 1. Also send A5 00 00 00 and require `LoadDone` with zero fill strobes.
- `MAX_WORDS`=4, send A5 00 05. Required response: `LoadErr`=1 after the 3rd byte, `ByteRdy`=0, no fills.
- Scenario 1 with random 0–3 cycle `ByteVal` gaps and `ADDR_BASE`=0x400. Required response: fills at 0x400 and 0x404 with the same data.
- `Restart` pulse after byte 7 of scenario 1, then the full frame resent. Required response:
  - `LoadDone`=0 and `CoreReset`=1 after the pulse;
  - the resent frame fills from addr 0x0 again, and `LoadDone` is set.
- Asynchronous `reset` low mid-word. Required response: all outputs take their reset values immediately, and a following clean frame loads correctly.
